// File: rtl/cmd_encode.sv
// Host-side command initiator for the USB-JTAG link: sends one 64-bit command as
// 8 bytes (MSB byte first) and optionally collects a 1-2 byte response with timeout.
module cmd_encode #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int GAP_CYC     = 1
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iCMD_Valid,
  output logic        oCMD_Ready,
  input  logic [7:0]  iCMD_Action,
  input  logic [7:0]  iCMD_Target,
  input  logic [23:0] iCMD_ADDR,
  input  logic [15:0] iCMD_DATA,
  input  logic [7:0]  iCMD_MODE,
  input  logic [1:0]  iRSP_LEN,
  output logic [7:0]  oTXD_DATA,
  output logic        oTXD_Start,
  input  logic        iTXD_Done,
  input  logic [7:0]  iRXD_DATA,
  input  logic        iRXD_Ready,
  output logic [15:0] oRSP_DATA,
  output logic        oRSP_Valid,
  output logic        oRSP_Timeout,
  output logic        oBusy
);

  localparam int GAP_N = (GAP_CYC < 1) ? 1 : GAP_CYC;
  localparam int GAP_W = (GAP_N > 1) ? $clog2(GAP_N) : 1;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_N - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_GAP  = 3'd2,
    S_RESP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [55:0]        cmd_q, cmd_d;
  logic [2:0]         idx_q, idx_d;
  logic [1:0]         len_q, len_d;
  logic [1:0]         rx_cnt_q, rx_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [7:0]         txd_data_q, txd_data_d;
  logic               start_q, start_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  // Next-state and registered-output computation for the transfer FSM.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    idx_d         = idx_q;
    len_d         = len_q;
    rx_cnt_d      = rx_cnt_q;
    gap_d         = gap_q;
    tmr_d         = tmr_q;
    txd_data_d    = txd_data_q;
    start_d       = start_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iCMD_Valid && ready_q) begin
          // Byte 0 goes straight to the output; the remaining 7 bytes are queued.
          cmd_d      = {iCMD_Target, iCMD_ADDR, iCMD_DATA, iCMD_MODE};
          txd_data_d = iCMD_Action;
          len_d      = (iRSP_LEN == 2'd3) ? 2'd2 : iRSP_LEN;
          idx_d      = 3'd0;
          rx_cnt_d   = 2'd0;
          rsp_data_d = 16'h0000;
          start_d    = 1'b1;
          state_d    = S_SEND;
        end else begin
          start_d = 1'b0;
        end
      end

      S_SEND: begin
        if (iTXD_Done) begin
          start_d = 1'b0;
          if (idx_q != 3'd7) begin
            gap_d   = {GAP_W{1'b0}};
            state_d = S_GAP;
          end else if (len_q == 2'd0) begin
            rsp_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            tmr_d   = {TMR_W{1'b0}};
            state_d = S_RESP;
          end
        end else begin
          start_d = 1'b1;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          idx_d      = idx_q + 3'd1;
          txd_data_d = cmd_q[55:48];
          cmd_d      = {cmd_q[47:0], 8'h00};
          start_d    = 1'b1;
          state_d    = S_SEND;
        end else begin
          gap_d = gap_q + {{(GAP_W-1){1'b0}}, 1'b1};
        end
      end

      S_RESP: begin
        // A received byte takes priority over a timer expiring in the same cycle.
        if (iRXD_Ready) begin
          tmr_d = {TMR_W{1'b0}};
          if (rx_cnt_q == 2'd0) begin
            rsp_data_d[7:0] = iRXD_DATA;
          end else begin
            rsp_data_d[15:8] = iRXD_DATA;
          end
          rx_cnt_d = rx_cnt_q + 2'd1;
          if ((rx_cnt_q + 2'd1) == len_q) begin
            rsp_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_RESP;
          end
        end else if (tmr_q == TMR_LAST) begin
          rsp_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmr_d = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; asynchronous reset drops any partial command.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q       <= S_IDLE;
      cmd_q         <= 56'h0;
      idx_q         <= 3'd0;
      len_q         <= 2'd0;
      rx_cnt_q      <= 2'd0;
      gap_q         <= {GAP_W{1'b0}};
      tmr_q         <= {TMR_W{1'b0}};
      txd_data_q    <= 8'h00;
      start_q       <= 1'b0;
      rsp_data_q    <= 16'h0000;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      rx_cnt_q      <= rx_cnt_d;
      gap_q         <= gap_d;
      tmr_q         <= tmr_d;
      txd_data_q    <= txd_data_d;
      start_q       <= start_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
    end
  end

  assign oCMD_Ready   = ready_q;
  assign oBusy        = busy_q;
  assign oTXD_DATA    = txd_data_q;
  assign oTXD_Start   = start_q;
  assign oRSP_DATA    = rsp_data_q;
  assign oRSP_Valid   = rsp_valid_q;
  assign oRSP_Timeout = rsp_timeout_q;

endmodule
